// File: rtl/reorder_buffer_mw.sv
// Multi-way reorder buffer: allocates DEC_WIDTH entries, accepts WB_PORTS writebacks and
// retires up to COM_WIDTH entries per cycle in program order, flushing on misses/exceptions.
package reorder_buffer_mw_pkg;
   typedef logic [3:0] ExpCode_t;
   localparam ExpCode_t EXP_ILLEGAL_INST = 4'd2;
endpackage

module reorder_buffer_mw
   import reorder_buffer_mw_pkg::*;
#(
   parameter int DATA      = 32,
   parameter int ADDR      = 32,
   parameter int ROB_DEPTH = 16,
   parameter int DEC_WIDTH = 2,
   parameter int WB_PORTS  = 2,
   parameter int COM_WIDTH = 2,
   parameter int REG       = 5,
   localparam int ROB      = $clog2(ROB_DEPTH),
   localparam int EW       = $bits(ExpCode_t)
) (
   input  logic                      clk,
   input  logic                      reset_,
   input  logic                      creg_exp_mask,
   input  logic [DATA-1:0]           creg_tvec,
   input  logic [DEC_WIDTH-1:0]      dec_e_,
   input  logic [DEC_WIDTH*ADDR-1:0] dec_pc,
   input  logic [DEC_WIDTH*REG-1:0]  dec_rd,
   input  logic [DEC_WIDTH-1:0]      dec_invalid,
   output logic [DEC_WIDTH*ROB-1:0]  dec_rob_id,
   output logic [ROB:0]              rob_free,
   output logic                      rob_busy,
   input  logic [WB_PORTS-1:0]       wb_e_,
   input  logic [WB_PORTS*ROB-1:0]   wb_rob_id,
   input  logic [WB_PORTS*DATA-1:0]  wb_data,
   input  logic [WB_PORTS-1:0]       wb_exp_,
   input  logic [WB_PORTS-1:0]       wb_pred_miss_,
   input  logic [WB_PORTS-1:0]       wb_jump_miss_,
   input  logic [WB_PORTS*EW-1:0]    wb_exp_code,
   input  logic [WB_PORTS*ADDR-1:0]  wb_target,
   output logic [COM_WIDTH-1:0]      commit_e_,
   output logic [COM_WIDTH*ADDR-1:0] commit_pc,
   output logic [COM_WIDTH*REG-1:0]  commit_rd,
   output logic [COM_WIDTH*DATA-1:0] commit_data,
   output logic [COM_WIDTH*ROB-1:0]  commit_rob_id,
   output logic                      commit_exp_,
   output ExpCode_t                  commit_exp_code,
   output logic                      flush_,
   output logic [ADDR-1:0]           flush_pc,
   output logic [ROB_DEPTH-1:0]      rob_ready
);

   logic [ROB-1:0]       head_r, tail_r;
   logic [ROB:0]         count_r;
   logic [ROB_DEPTH-1:0] valid_r, done_r, exp_r, miss_r;
   logic [ADDR-1:0]      pc_r     [ROB_DEPTH];
   logic [REG-1:0]       rd_r     [ROB_DEPTH];
   logic [DATA-1:0]      data_r   [ROB_DEPTH];
   ExpCode_t             exp_code_r [ROB_DEPTH];
   logic [ADDR-1:0]      target_r [ROB_DEPTH];

   logic [COM_WIDTH-1:0] com_en_s;
   logic [ROB:0]         com_n_s, alloc_n_s, alloc_eff_s, free_s;
   logic                 flush_s, exp_flush_s, alloc_go_s;
   logic [ADDR-1:0]      flush_pc_s;
   ExpCode_t             exp_code_s;

   assign free_s      = (ROB+1)'(ROB_DEPTH) - count_r;
   assign rob_free    = free_s;
   assign rob_busy    = free_s < (ROB+1)'(DEC_WIDTH);
   assign rob_ready   = valid_r & done_r;
   assign alloc_go_s  = !rob_busy && !flush_s;
   assign alloc_eff_s = alloc_go_s ? alloc_n_s : (ROB+1)'(0);

   assign commit_e_       = ~com_en_s;
   assign flush_          = ~flush_s;
   assign flush_pc        = flush_pc_s;
   assign commit_exp_     = ~exp_flush_s;
   assign commit_exp_code = exp_code_s;

   for (genvar k = 0; k < DEC_WIDTH; k++) begin : g_dec_id
      assign dec_rob_id[k*ROB +: ROB] = tail_r + ROB'(k);
   end

   // Count enabled decode slots (slots are contiguous from slot 0)
   always_comb begin
      alloc_n_s = '0;
      for (int k = 0; k < DEC_WIDTH; k++) begin
         if (!dec_e_[k]) begin
            alloc_n_s = alloc_n_s + (ROB+1)'(1);
         end else begin
            alloc_n_s = alloc_n_s;
         end
      end
   end

   // Commit group selection; a flushing entry retires but ends the group
   always_comb begin
      logic           run_s;
      logic [ROB-1:0] idx_s;
      logic           exp_hit_s;
      com_en_s      = '0;
      com_n_s       = '0;
      flush_s       = 1'b0;
      exp_flush_s   = 1'b0;
      flush_pc_s    = '0;
      exp_code_s    = '0;
      commit_pc     = '0;
      commit_rd     = '0;
      commit_data   = '0;
      commit_rob_id = '0;
      run_s         = 1'b1;
      for (int k = 0; k < COM_WIDTH; k++) begin
         idx_s     = head_r + ROB'(k);
         exp_hit_s = exp_r[idx_s] && !creg_exp_mask;
         commit_pc[k*ADDR +: ADDR]    = pc_r[idx_s];
         commit_rd[k*REG +: REG]      = rd_r[idx_s];
         commit_data[k*DATA +: DATA]  = data_r[idx_s];
         commit_rob_id[k*ROB +: ROB]  = idx_s;
         if (run_s && valid_r[idx_s] && done_r[idx_s]) begin
            com_en_s[k] = 1'b1;
            com_n_s     = com_n_s + (ROB+1)'(1);
            if (exp_hit_s) begin
               flush_s     = 1'b1;
               exp_flush_s = 1'b1;
               flush_pc_s  = ADDR'(creg_tvec);
               exp_code_s  = exp_code_r[idx_s];
               run_s       = 1'b0;
            end else if (miss_r[idx_s]) begin
               flush_s    = 1'b1;
               flush_pc_s = target_r[idx_s];
               run_s      = 1'b0;
            end else begin
               run_s = 1'b1;
            end
         end else begin
            run_s = 1'b0;
         end
      end
   end

   // Entry state: writeback (lower port wins), allocation, retirement, flush clear
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         valid_r <= '0;
         done_r  <= '0;
         exp_r   <= '0;
         miss_r  <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            pc_r[i]       <= '0;
            rd_r[i]       <= '0;
            data_r[i]     <= '0;
            exp_code_r[i] <= '0;
            target_r[i]   <= '0;
         end
      end else if (flush_s) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         valid_r <= '0;
         done_r  <= '0;
      end else begin
         for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (!wb_e_[p] && valid_r[wb_rob_id[p*ROB +: ROB]]) begin
               done_r[wb_rob_id[p*ROB +: ROB]]     <= 1'b1;
               data_r[wb_rob_id[p*ROB +: ROB]]     <= wb_data[p*DATA +: DATA];
               exp_r[wb_rob_id[p*ROB +: ROB]]      <= !wb_exp_[p];
               exp_code_r[wb_rob_id[p*ROB +: ROB]] <= wb_exp_code[p*EW +: EW];
               miss_r[wb_rob_id[p*ROB +: ROB]]     <= !wb_pred_miss_[p] || !wb_jump_miss_[p];
               target_r[wb_rob_id[p*ROB +: ROB]]   <= wb_target[p*ADDR +: ADDR];
            end
         end
         for (int k = 0; k < DEC_WIDTH; k++) begin
            if (alloc_go_s && !dec_e_[k]) begin
               valid_r[tail_r + ROB'(k)]    <= 1'b1;
               done_r[tail_r + ROB'(k)]     <= dec_invalid[k];
               pc_r[tail_r + ROB'(k)]       <= dec_pc[k*ADDR +: ADDR];
               rd_r[tail_r + ROB'(k)]       <= dec_rd[k*REG +: REG];
               data_r[tail_r + ROB'(k)]     <= '0;
               exp_r[tail_r + ROB'(k)]      <= dec_invalid[k];
               exp_code_r[tail_r + ROB'(k)] <= dec_invalid[k] ? EXP_ILLEGAL_INST : ExpCode_t'(0);
               miss_r[tail_r + ROB'(k)]     <= 1'b0;
               target_r[tail_r + ROB'(k)]   <= '0;
            end
         end
         for (int k = 0; k < COM_WIDTH; k++) begin
            if (com_en_s[k]) begin
               valid_r[head_r + ROB'(k)] <= 1'b0;
               done_r[head_r + ROB'(k)]  <= 1'b0;
            end
         end
         head_r  <= head_r + com_n_s[ROB-1:0];
         tail_r  <= tail_r + alloc_eff_s[ROB-1:0];
         count_r <= count_r + alloc_eff_s - com_n_s;
      end
   end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Directed bench for reorder_buffer_mw with a program-order commit scoreboard.
module tb_reorder_buffer_mw;
   import reorder_buffer_mw_pkg::*;

   localparam int R = 4;

   logic          clk = 1'b0;
   logic          reset_;
   logic          creg_exp_mask;
   logic [31:0]   creg_tvec;
   logic [1:0]    dec_e_;
   logic [63:0]   dec_pc;
   logic [9:0]    dec_rd;
   logic [1:0]    dec_invalid;
   logic [7:0]    dec_rob_id;
   logic [4:0]    rob_free;
   logic          rob_busy;
   logic [1:0]    wb_e_;
   logic [7:0]    wb_rob_id;
   logic [63:0]   wb_data;
   logic [1:0]    wb_exp_, wb_pred_miss_, wb_jump_miss_;
   logic [7:0]    wb_exp_code;
   logic [63:0]   wb_target;
   logic [1:0]    commit_e_;
   logic [63:0]   commit_pc;
   logic [9:0]    commit_rd;
   logic [63:0]   commit_data;
   logic [7:0]    commit_rob_id;
   logic          commit_exp_;
   ExpCode_t      commit_exp_code;
   logic          flush_;
   logic [31:0]   flush_pc;
   logic [15:0]   rob_ready;

   reorder_buffer_mw dut (
      .clk(clk), .reset_(reset_), .creg_exp_mask(creg_exp_mask), .creg_tvec(creg_tvec),
      .dec_e_(dec_e_), .dec_pc(dec_pc), .dec_rd(dec_rd), .dec_invalid(dec_invalid),
      .dec_rob_id(dec_rob_id), .rob_free(rob_free), .rob_busy(rob_busy),
      .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_data(wb_data), .wb_exp_(wb_exp_),
      .wb_pred_miss_(wb_pred_miss_), .wb_jump_miss_(wb_jump_miss_), .wb_exp_code(wb_exp_code),
      .wb_target(wb_target), .commit_e_(commit_e_), .commit_pc(commit_pc), .commit_rd(commit_rd),
      .commit_data(commit_data), .commit_rob_id(commit_rob_id), .commit_exp_(commit_exp_),
      .commit_exp_code(commit_exp_code), .flush_(flush_), .flush_pc(flush_pc), .rob_ready(rob_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] pc;
      logic [4:0]  rd;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         mon_e;
   logic [31:0] exp_d [16];
   logic [3:0]  tb_tail;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_decode(input int n, input logic [31:0] pc0, input logic [4:0] rd0,
                            input logic inv, input bit accept);
      sb_t e;
      dec_e_ = 2'b11;
      for (int k = 0; k < n; k++) begin
         dec_e_[k]            = 1'b0;
         dec_pc[k*32 +: 32]   = pc0 + 32'(4*k);
         dec_rd[k*5 +: 5]     = rd0 + 5'(k);
         dec_invalid[k]       = inv;
         if (accept) begin
            chk("dec_rob_id", 64'(dec_rob_id[k*R +: R]), 64'(tb_tail + 4'(k)));
            e.id = tb_tail + 4'(k);
            e.pc = pc0 + 32'(4*k);
            e.rd = rd0 + 5'(k);
            sb_q.push_back(e);
            if (inv) exp_d[e.id] = 32'h0;
         end
      end
      if (accept) tb_tail = tb_tail + 4'(n);
      tick();
      dec_e_      = 2'b11;
      dec_invalid = 2'b00;
   endtask

   task automatic wb(input int port, input logic [3:0] id, input logic [31:0] d,
                     input logic miss, input logic [31:0] tgt);
      wb_e_[port]                = 1'b0;
      wb_rob_id[port*R +: R]     = id;
      wb_data[port*32 +: 32]     = d;
      wb_pred_miss_[port]        = !miss;
      wb_target[port*32 +: 32]   = tgt;
      exp_d[id]                  = d;
   endtask

   task automatic wb_clear();
      wb_e_         = 2'b11;
      wb_pred_miss_ = 2'b11;
   endtask

   // Scoreboard: every retiring slot must match the oldest outstanding decode
   always @(negedge clk) begin
      if (reset_) begin
         for (int k = 0; k < 2; k++) begin
            if (commit_e_[k] === 1'b0) begin
               checks++;
               assert (sb_q.size() != 0) else begin
                  errors++;
                  $error("FAIL commit_unexpected observed=id%0d expected=none", commit_rob_id[k*R +: R]);
               end
               if (sb_q.size() != 0) begin
                  mon_e = sb_q.pop_front();
                  chk("commit_rob_id", 64'(commit_rob_id[k*R +: R]), 64'(mon_e.id));
                  chk("commit_pc", 64'(commit_pc[k*32 +: 32]), 64'(mon_e.pc));
                  chk("commit_rd", 64'(commit_rd[k*5 +: 5]), 64'(mon_e.rd));
                  chk("commit_data", 64'(commit_data[k*32 +: 32]), 64'(exp_d[mon_e.id]));
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] perm [15];
      logic [3:0] t;
      int         j;
      reset_ = 1'b0; creg_exp_mask = 1'b0; creg_tvec = 32'h0;
      dec_e_ = 2'b11; dec_pc = 64'h0; dec_rd = 10'h0; dec_invalid = 2'b00;
      wb_e_ = 2'b11; wb_rob_id = 8'h0; wb_data = 64'h0; wb_exp_ = 2'b11;
      wb_pred_miss_ = 2'b11; wb_jump_miss_ = 2'b11; wb_exp_code = 8'h0; wb_target = 64'h0;
      tb_tail = 4'd0;
      for (int i = 0; i < 16; i++) exp_d[i] = 32'h0;

      // Reset then idle
      #12;
      chk("rst_rob_free", 64'(rob_free), 64'd16);
      chk("rst_rob_busy", 64'(rob_busy), 64'd0);
      chk("rst_commit_e", 64'(commit_e_), 64'h3);
      chk("rst_flush", 64'(flush_), 64'd1);
      chk("rst_commit_exp", 64'(commit_exp_), 64'd1);
      chk("rst_rob_ready", 64'(rob_ready), 64'd0);
      chk("rst_dec_rob_id", 64'(dec_rob_id), 64'h10);
      @(negedge clk); reset_ = 1'b1;
      tick();

      // Dual retire
      do_decode(2, 32'hcafe0000, 5'd1, 1'b0, 1'b1);
      wb(0, 4'd1, 32'h22, 1'b0, 32'h0); tick(); wb_clear();
      chk("dual_not_yet", 64'(commit_e_), 64'h3);
      wb(0, 4'd0, 32'h11, 1'b0, 32'h0); tick(); wb_clear();
      chk("dual_commit_e", 64'(commit_e_), 64'h0);
      chk("dual_commit_data", commit_data, {32'h22, 32'h11});
      tick();
      chk("dual_rob_free", 64'(rob_free), 64'd16);

      // Unmasked exception on an illegal instruction (ID2)
      creg_tvec = 32'h0003caf8;
      do_decode(1, 32'h00001000, 5'd7, 1'b1, 1'b1);
      chk("exp_commit_e", 64'(commit_e_), 64'h2);
      chk("exp_commit_exp", 64'(commit_exp_), 64'd0);
      chk("exp_code", 64'(commit_exp_code), 64'(EXP_ILLEGAL_INST));
      chk("exp_flush", 64'(flush_), 64'd0);
      chk("exp_flush_pc", 64'(flush_pc), 64'h0003caf8);
      tick();
      sb_q.delete(); tb_tail = 4'd0;
      chk("exp_rob_free", 64'(rob_free), 64'd16);

      // Write collision on ID0: port 0 must win
      do_decode(1, 32'h00002000, 5'd3, 1'b0, 1'b1);
      wb(1, 4'd0, 32'hbbbb, 1'b0, 32'h0);
      wb(0, 4'd0, 32'haaaa, 1'b0, 32'h0);
      tick(); wb_clear();
      chk("coll_commit_data", 64'(commit_data[31:0]), 64'haaaa);
      tick();

      // Fill to 15 entries (IDs 1..15), then a dropped decode
      for (int i = 0; i < 7; i++) do_decode(2, 32'h00010000 + 32'(8*i), 5'(2*i+1), 1'b0, 1'b1);
      chk("fill14_busy", 64'(rob_busy), 64'd0);
      chk("fill14_free", 64'(rob_free), 64'd2);
      do_decode(1, 32'h00010038, 5'd20, 1'b0, 1'b1);
      chk("fill15_busy", 64'(rob_busy), 64'd1);
      chk("fill15_free", 64'(rob_free), 64'd1);
      do_decode(2, 32'hdead0000, 5'd9, 1'b0, 1'b0);
      chk("drop_free", 64'(rob_free), 64'd1);
      chk("drop_tail", 64'(dec_rob_id[3:0]), 64'd0);

      // Random-order writeback; scoreboard enforces program order
      for (int i = 0; i < 15; i++) perm[i] = 4'(i + 1);
      for (int i = 14; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 15; i++) begin
         wb(0, perm[i], 32'h1000 + 32'(perm[i]), 1'b0, 32'h0);
         tick(); wb_clear();
      end
      for (int c = 0; c < 40 && sb_q.size() != 0; c++) tick();
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
      chk("drain_free", 64'(rob_free), 64'd16);

      // Wrapped allocation gets IDs 0..3, then 4,5 for the branch test
      do_decode(2, 32'h00020000, 5'd1, 1'b0, 1'b1);
      do_decode(2, 32'h00020008, 5'd3, 1'b0, 1'b1);
      do_decode(2, 32'h00020010, 5'd5, 1'b0, 1'b1);

      // Branch miss at ID2 with ID3 also done
      wb(0, 4'd0, 32'h300, 1'b0, 32'h0);
      wb(1, 4'd1, 32'h301, 1'b0, 32'h0);
      tick(); wb_clear();
      wb(0, 4'd3, 32'h303, 1'b0, 32'h0);
      wb(1, 4'd2, 32'h302, 1'b1, 32'hbeef0100);
      tick(); wb_clear();
      chk("br_commit_e", 64'(commit_e_), 64'h2);
      chk("br_flush", 64'(flush_), 64'd0);
      chk("br_flush_pc", 64'(flush_pc), 64'hbeef0100);
      chk("br_commit_exp", 64'(commit_exp_), 64'd1);
      tick();
      sb_q.delete(); tb_tail = 4'd0;
      chk("br_rob_free", 64'(rob_free), 64'd16);
      chk("br_flush_gone", 64'(flush_), 64'd1);

      // Masked exception retires as a normal instruction
      creg_exp_mask = 1'b1;
      do_decode(1, 32'h00003000, 5'd4, 1'b1, 1'b1);
      chk("mexp_commit_e", 64'(commit_e_), 64'h2);
      chk("mexp_flush", 64'(flush_), 64'd1);
      chk("mexp_commit_exp", 64'(commit_exp_), 64'd1);
      tick();
      chk("mexp_rob_free", 64'(rob_free), 64'd16);

      // Reset asserted mid-operation clears state immediately
      do_decode(2, 32'h00004000, 5'd6, 1'b1, 1'b1);
      reset_ = 1'b0;
      #1;
      chk("mrst_commit_e", 64'(commit_e_), 64'h3);
      chk("mrst_rob_free", 64'(rob_free), 64'd16);
      chk("mrst_rob_ready", 64'(rob_ready), 64'd0);
      chk("mrst_dec_rob_id", 64'(dec_rob_id), 64'h10);
      sb_q.delete(); tb_tail = 4'd0;
      @(negedge clk); reset_ = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer_mw.md
# reorder_buffer_mw

Multi-way, parametrised reorder buffer: it allocates up to DEC_WIDTH entries per cycle from decode and accepts up to WB_PORTS out-of-order writebacks per cycle. It retires up to COM_WIDTH completed entries per cycle, in program order, and raises a pipeline flush with a redirect PC on branch/jump mispredictions and unmasked exceptions. It sits between decode/rename and the register file and commit stage. It replaces the single-issue ROB on wide configurations.

## Interface
- DATA, 32, data width
- ADDR, 32, PC width
- ROB_DEPTH, 16, entries; must be a power of 2 and at least DEC_WIDTH; ROB = $clog2(ROB_DEPTH)
- DEC_WIDTH, 2, decode slots per cycle
- WB_PORTS, 2, writeback ports
- COM_WIDTH, 2, commit slots per cycle
- REG, 5, architectural register address width; address 0 means no destination
- clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- creg_exp_mask  in  1  when 1, exceptions retire as normal instructions (no flush, commit_exp_ stays disabled)
- creg_tvec  in  DATA  exception handler PC
- dec_e_  in  DEC_WIDTH  per-slot enable, active-low; enabled slots are contiguous from slot 0
- dec_pc  in  DEC_WIDTH*ADDR  per-slot PC
- dec_rd  in  DEC_WIDTH*REG  per-slot destination register
- dec_invalid  in  DEC_WIDTH  illegal instruction; the entry is allocated already complete, with exception EXP_ILLEGAL_INST
- dec_rob_id  out  DEC_WIDTH*ROB  ID assigned to slot k = tail+k (combinational)
- rob_free  out  ROB+1  number of free entries
- rob_busy  out  1  high when rob_free < DEC_WIDTH
- wb_e_  in  WB_PORTS  per-port writeback enable, active-low
- wb_rob_id  in  WB_PORTS*ROB  target entry
- wb_data  in  WB_PORTS*DATA  result
- wb_exp_, wb_pred_miss_, wb_jump_miss_  in  WB_PORTS each  active-low status flags
- wb_exp_code  in  WB_PORTS*ExpCode_t  exception code
- wb_target  in  WB_PORTS*ADDR  correct target for a miss
- commit_e_  out  COM_WIDTH  per-slot commit, active-low
- commit_pc, commit_rd, commit_data, commit_rob_id  out  per-slot ADDR/REG/DATA/ROB  retiring entry fields
- commit_exp_  out  1  active-low; the group ends in an exception
- commit_exp_code  out  ExpCode_t  code of that exception
- flush_  out  1  active-low pipeline flush
- flush_pc  out  ADDR  redirect PC
- rob_ready  out  ROB_DEPTH  per-entry valid & done bit, for wakeup

## Operation
- Storage is a circular array with head, tail and count registers. Pointers wrap modulo ROB_DEPTH.
- Each entry holds: valid, done, pc, rd, data, exp, exp_code, miss, target.
- **Allocate:** only when rob_busy is low. Slot k writes entry tail+k with valid=1, done=dec_invalid[k]. The tail advances by the number of enabled slots. Decode while rob_busy is high is dropped and nothing is allocated.
- **Writeback:** sets done and latches data and flags. A writeback to an entry that is not valid is ignored. When two ports hit the same ID in one cycle, the lower port index wins.
- **Commit slot k** is enabled iff entries head..head+k are all valid & done and no earlier slot in the group is a flushing entry.
  - A flushing entry is one with miss set, or with exp set and creg_exp_mask=0.
  - A flushing entry may occupy any slot but terminates the group.
- **Flush:** asserted combinationally in the cycle its entry is presented on commit.
  - flush_pc = creg_tvec for an exception, otherwise the stored target.
  - For an exception, commit_exp_ is enabled and commit_exp_code is driven.
  - At that edge all entries are invalidated and head, tail and count are cleared.
  - Decode and writeback in the flush cycle are discarded.
- Commit outputs are combinational from registered state. The head advances and count decrements at the edge.
- rob_free and rob_busy use pre-commit count. Entries freed by commit become allocatable the next cycle.

## Timing
- Reset values:
  - head, tail, count, valid and done all 0
  - commit_e_ all 1; flush_ 1; commit_exp_ 1
  - rob_busy 0; rob_free ROB_DEPTH; rob_ready 0
  - dec_rob_id[k] = k
- Writeback at edge N makes the entry committable in cycle N+1; it retires at edge N+1. Minimum decode-to-commit latency is 2 edges.
- Allocation and commit may occur in the same cycle. The count update is +alloc −commit.
- Full (count = ROB_DEPTH) forces rob_busy = 1. Empty forces all commit_e_ disabled.
- Asserting reset mid-operation clears state asynchronously. Outputs return to their reset values immediately.

## Test plan
- **Reset then idle:** rob_free=16, rob_busy=0, commit_e_=2'b11, flush_=1.
- **Dual retire:**
  - Decode two slots: pc 0xcafe0000/0xcafe0004, rd 1/2 → IDs 0/1.
  - Write back ID1 (0x22) then ID0 (0x11) one cycle apart.
  - Required: both retire in one cycle with commit_data 0x11/0x22. rob_free returns to 16.
- **Fill and wrap:**
  - Fill 16 entries → rob_busy=1 at count 15. Further decode is dropped.
  - Random-order writeback → commits stay in program order.
  - A further 4 decodes receive IDs 0..3 after the wrap.
- **Branch miss:**
  - ID2 written back with wb_pred_miss_=0, wb_target=0xbeef0100, while IDs 3..5 are valid.
  - Required: ID2 commits with flush_=0 and flush_pc=0xbeef0100; a later slot in that cycle is disabled. The next cycle shows rob_free=16.
- **Exception:**
  - With creg_tvec=0x0003caf8 and an invalid decode → commit_exp_=0, code EXP_ILLEGAL_INST, flush_pc=0x0003caf8.
  - Same stimulus with creg_exp_mask=1 → commit without flush.
- **Write collision:** ports 0 and 1 both write ID0 (0xaaaa / 0xbbbb) → commit_data=0xaaaa.
